division_unit: RTL
==================

Name: division_unit

Overview:
- Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- It is the inverse operation to the existing multiplier and uses the same START/STALL/READY handshake style, so the execute stage drives both blocks the same way.
- Produces quotient and remainder together. RISC-V corner-case results (divide-by-zero, signed overflow) are built in.

Parameters:
- INPUT_WIDTH, 32, operand width; quotient and remainder are each INPUT_WIDTH bits.

Ports:
- CLK  input  1  clock, rising-edge.
- RSTN  input  1  reset, asynchronous, active-low.
- STALL_DIV  input  1  pipeline stall; when high all internal state and outputs freeze.
- START  input  1  begin a new division; sampled only when STALL_DIV low.
- SIGN  input  1  1 = signed (DIV/REM), both operands two's complement; 0 = unsigned.
- DIVIDEND  input  INPUT_WIDTH  numerator, sampled with START.
- DIVISOR  input  INPUT_WIDTH  denominator, sampled with START.
- QUOTIENT_OUT  output  INPUT_WIDTH  quotient of last completed operation.
- REMAINDER_OUT  output  INPUT_WIDTH  remainder of last completed operation.
- READY  output  1  high when idle and outputs are valid.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, QUOTIENT_OUT=0, REMAINDER_OUT=0, READY=1, iteration counter=0.
- States:
  - IDLE: READY=1. On START, go to CALC.
  - CALC: runs INPUT_WIDTH iterations, then goes to FIX.
  - FIX: one cycle; updates outputs and returns to IDLE.
- START edge (E0):
  - Latch absolute values |DIVIDEND| and |DIVISOR| (magnitude only if SIGN=1 and MSB set).
  - Latch neg_q = SIGN & (DIVIDEND MSB ^ DIVISOR MSB).
  - Latch neg_r = SIGN & DIVIDEND MSB.
  - Latch the divide-by-zero flag (DIVISOR==0).
  - Latch the overflow flag (SIGN & DIVIDEND==100..0 & DIVISOR==all ones).
  - Clear the partial remainder and load the counter with INPUT_WIDTH.
- CALC, each unstalled edge:
  - Compute {rem,quo} = {rem,quo}<<1.
  - If rem >= divisor: rem -= divisor, quo[0]=1.
  - Decrement counter; at counter==1 go to FIX.
  - The partial remainder is INPUT_WIDTH+1 bits wide to absorb the shift carry.
- FIX edge selects the outputs:
  - Divide-by-zero: QUOTIENT_OUT = all ones; REMAINDER_OUT = original DIVIDEND.
  - Overflow: QUOTIENT_OUT = DIVIDEND (0x80000000); REMAINDER_OUT = 0.
  - Otherwise: QUOTIENT_OUT = neg_q ? -quo : quo; REMAINDER_OUT = neg_r ? -rem : rem.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Latency:
  - START sampled at edge E0; READY low from E0 until edge E(INPUT_WIDTH+1).
  - READY is high and outputs are valid after E(INPUT_WIDTH+1), i.e. 33 busy cycles at default width.
- Stall: STALL_DIV high freezes state, counter, outputs and READY. Stall cycles add directly to latency. START is ignored while stalled.
- START while busy (CALC/FIX): aborts the current operation and restarts with the new operands. The aborted result is never written to the outputs.
- Outputs hold their last value until the next FIX. Intermediate CALC values are never visible on the outputs.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- Unsigned mode (SIGN=0) never asserts the overflow flag.

Optional Feature:
- Macro: DIVISION_EARLY_OUT_EN.
- Defined:
  - Divide-by-zero, signed overflow, and |DIVIDEND| < |DIVISOR| skip CALC and go from START straight to FIX.
  - The result is valid after edge E1, so READY is low for exactly 1 cycle.
  - The |DIVIDEND| < |DIVISOR| case gives quotient 0 and remainder = DIVIDEND.
- Undefined: every operation takes the full INPUT_WIDTH+1 busy cycles. Results are bit-identical to the defined case.

Test Plan:
- Unsigned 100/7 (SIGN=0) -> Q=14, R=2; READY low exactly 33 cycles, no stall.
- Signed -7/2 (SIGN=1, 0xFFFFFFF9 / 2) -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1); and 7/-2 -> Q=-3, R=1.
- Divide-by-zero: 0x12345678/0, SIGN=1 and SIGN=0 -> Q=0xFFFFFFFF, R=0x12345678; with DIVISION_EARLY_OUT_EN, READY low 1 cycle.
- Signed overflow 0x80000000/0xFFFFFFFF, SIGN=1 -> Q=0x80000000, R=0. With SIGN=0 -> Q=0, R=0x80000000.
- Stall and restart:
  - Stall 5 cycles mid-CALC on 1000/10 -> Q=100, R=0 after 38 cycles.
  - Re-assert START with 9/4 at iteration 10 -> only Q=2, R=1 ever appears on the outputs.
- Reset: drop RSTN mid-CALC -> asynchronously READY=1, QUOTIENT_OUT=0, REMAINDER_OUT=0; the next operation (50/5 -> Q=10, R=0) completes correctly.

Source files
------------

// File: rtl/division_unit.sv
// -----------------------------------------------------------------------------
// division_unit
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Quotient and remainder are produced together. The RISC-V corner cases
// (divide-by-zero and signed overflow) are resolved in the FIX state.
// The START/STALL/READY handshake matches the multiplier's.
//
// Optional feature (macro DIVISION_EARLY_OUT_EN):
//   when defined, the following cases skip CALC and go straight to FIX,
//   so READY is low for a single cycle:
//     - divide-by-zero
//     - signed overflow
//     - |DIVIDEND| < |DIVISOR|
//   Results are bit-identical to the full-length build.
//
// Ports:
//   CLK           rising-edge clock
//   RSTN          asynchronous active-low reset
//   STALL_DIV     freezes all state and outputs while high
//   START         begin (or abort and restart) a division; ignored while stalled
//   SIGN          1 = signed operands (DIV/REM), 0 = unsigned (DIVU/REMU)
//   DIVIDEND      numerator, sampled with START
//   DIVISOR       denominator, sampled with START
//   QUOTIENT_OUT  quotient of the last completed operation
//   REMAINDER_OUT remainder of the last completed operation
//   READY         high when idle and the outputs are valid
// -----------------------------------------------------------------------------
module division_unit #(
  parameter int INPUT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   STALL_DIV,
  input  logic                   START,
  input  logic                   SIGN,
  input  logic [INPUT_WIDTH-1:0] DIVIDEND,
  input  logic [INPUT_WIDTH-1:0] DIVISOR,
  output logic [INPUT_WIDTH-1:0] QUOTIENT_OUT,
  output logic [INPUT_WIDTH-1:0] REMAINDER_OUT,
  output logic                   READY
);

  localparam int W  = INPUT_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation.
  function automatic logic [W-1:0] neg_val(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; only negative signed values are flipped.
  function automatic logic [W-1:0] mag_val(input logic [W-1:0] v, input logic sgn);
    logic [W-1:0] m;
    if (sgn && v[W-1]) begin
      m = neg_val(v);
    end else begin
      m = v;
    end
    return m;
  endfunction

  state_t         state_r, state_nx_s;
  logic [CW-1:0]  cnt_r, cnt_nx_s;
  logic [W-1:0]   rem_r, rem_nx_s;
  logic [W-1:0]   quo_r, quo_nx_s;
  logic [W-1:0]   dvs_r, dvs_nx_s;
  logic [W-1:0]   dvd_r, dvd_nx_s;
  logic           neg_q_r, neg_q_nx_s;
  logic           neg_r_r, neg_r_nx_s;
  logic           dz_r, dz_nx_s;
  logic           ov_r, ov_nx_s;
  logic [W-1:0]   q_out_r, q_out_nx_s;
  logic [W-1:0]   r_out_r, r_out_nx_s;
  logic           ready_r, ready_nx_s;

  logic [W-1:0]   abs_dvd_s, abs_dvs_s;
  logic           dz_s, ov_s, lt_s, early_s;
  logic [W:0]     rem_sh_s;
  logic           ge_s;

  assign abs_dvd_s = mag_val(DIVIDEND, SIGN);
  assign abs_dvs_s = mag_val(DIVISOR, SIGN);
  assign dz_s      = (DIVISOR == {W{1'b0}});
  assign ov_s      = SIGN & (DIVIDEND == {1'b1, {(W-1){1'b0}}}) & (DIVISOR == {W{1'b1}});

`ifdef DIVISION_EARLY_OUT_EN
  // A dividend smaller than the divisor has quotient 0 and needs no iterations.
  assign lt_s    = (abs_dvd_s < abs_dvs_s);
  assign early_s = dz_s | ov_s | lt_s;
`else
  assign lt_s    = 1'b0;
  assign early_s = 1'b0;
`endif

  // The partial remainder is one bit wider than an operand.
  // The extra bit holds the carry shifted out of rem before the compare.
  assign rem_sh_s = {rem_r, quo_r[W-1]};
  assign ge_s     = (rem_sh_s >= {1'b0, dvs_r});

  assign QUOTIENT_OUT  = q_out_r;
  assign REMAINDER_OUT = r_out_r;
  assign READY         = ready_r;

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  // An unstalled START restarts from any state, aborting a busy operation.
  always_comb begin
    state_nx_s = state_r;
    if (STALL_DIV) begin
      state_nx_s = state_r;
    end else if (START) begin
      state_nx_s = early_s ? FIX : CALC;
    end else begin
      case (state_r)
        IDLE:    state_nx_s = IDLE;
        CALC:    state_nx_s = (cnt_r == CW'(1)) ? FIX : CALC;
        FIX:     state_nx_s = IDLE;
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Datapath and output next-value logic; every register holds by default.
  always_comb begin
    cnt_nx_s   = cnt_r;
    rem_nx_s   = rem_r;
    quo_nx_s   = quo_r;
    dvs_nx_s   = dvs_r;
    dvd_nx_s   = dvd_r;
    neg_q_nx_s = neg_q_r;
    neg_r_nx_s = neg_r_r;
    dz_nx_s    = dz_r;
    ov_nx_s    = ov_r;
    q_out_nx_s = q_out_r;
    r_out_nx_s = r_out_r;
    ready_nx_s = ready_r;
    if (STALL_DIV) begin
      ready_nx_s = ready_r;
    end else if (START) begin
      // The early-out "less than" case preloads the final remainder.
      // Its quotient is zero, so FIX only has to apply the signs.
      quo_nx_s   = lt_s ? {W{1'b0}} : abs_dvd_s;
      rem_nx_s   = lt_s ? abs_dvd_s : {W{1'b0}};
      dvs_nx_s   = abs_dvs_s;
      dvd_nx_s   = DIVIDEND;
      neg_q_nx_s = SIGN & (DIVIDEND[W-1] ^ DIVISOR[W-1]);
      neg_r_nx_s = SIGN & DIVIDEND[W-1];
      dz_nx_s    = dz_s;
      ov_nx_s    = ov_s;
      cnt_nx_s   = CW'(W);
      ready_nx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready_nx_s = 1'b1;
        end
        CALC: begin
          quo_nx_s = {quo_r[W-2:0], ge_s};
          rem_nx_s = ge_s ? W'(rem_sh_s - {1'b0, dvs_r}) : rem_sh_s[W-1:0];
          cnt_nx_s = cnt_r - CW'(1);
        end
        FIX: begin
          if (dz_r) begin
            q_out_nx_s = {W{1'b1}};
            r_out_nx_s = dvd_r;
          end else if (ov_r) begin
            q_out_nx_s = dvd_r;
            r_out_nx_s = {W{1'b0}};
          end else begin
            q_out_nx_s = neg_q_r ? neg_val(quo_r) : quo_r;
            r_out_nx_s = neg_r_r ? neg_val(rem_r) : rem_r;
          end
          ready_nx_s = 1'b1;
        end
        default: begin
          ready_nx_s = 1'b1;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_r   <= {CW{1'b0}};
      rem_r   <= {W{1'b0}};
      quo_r   <= {W{1'b0}};
      dvs_r   <= {W{1'b0}};
      dvd_r   <= {W{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      ov_r    <= 1'b0;
      q_out_r <= {W{1'b0}};
      r_out_r <= {W{1'b0}};
      ready_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_nx_s;
      rem_r   <= rem_nx_s;
      quo_r   <= quo_nx_s;
      dvs_r   <= dvs_nx_s;
      dvd_r   <= dvd_nx_s;
      neg_q_r <= neg_q_nx_s;
      neg_r_r <= neg_r_nx_s;
      dz_r    <= dz_nx_s;
      ov_r    <= ov_nx_s;
      q_out_r <= q_out_nx_s;
      r_out_r <= r_out_nx_s;
      ready_r <= ready_nx_s;
    end
  end

endmodule
